// File: rtl/us_echo_detector_if.sv
// ----------------------------------------------------------------------------
// us_echo_detector_if
//  One FSL link: a data word, its control flag, and both flow-control views.
//  The writer side sees write/full. The reader side sees exists/read.
//  A word transfers on the clock edge where the reader asserts read
//  (slave side) or the writer asserts write (master side).
//
//  Signals
//   data     32  payload word
//   control   1  1 = header / control word
//   exists    1  reader side: a word is available
//   read      1  reader side: consume the current word
//   write     1  writer side: the offered word is valid
//   full      1  writer side: the consumer cannot accept
// ----------------------------------------------------------------------------
interface us_echo_detector_if;
    logic [31:0] data;
    logic        control;
    logic        exists;
    logic        read;
    logic        write;
    logic        full;

    // Producer of an FSL stream (this block's result output).
    modport master (
        output data,
        output control,
        output write,
        input  full
    );

    // Consumer of an FSL stream (this block's sample input).
    modport slave (
        input  data,
        input  control,
        input  exists,
        output read
    );
endinterface

// File: rtl/us_echo_detector.sv
// ----------------------------------------------------------------------------
// us_echo_detector
//  Consumes the us_receiver sample stream. Each packet is one control header
//  followed by N ADC sample words. For each packet the block finds the first
//  sample at or above the threshold and the peak amplitude. It then emits a
//  two-word result packet: a copy of the header, then one result word.
//
//  Ports
//   FSL_Clk     in     sole clock, rising edge
//   FSL_Rst_n   in     asynchronous active-low reset
//   THRESHOLD   in     echo threshold, latched when a header is accepted
//   fsl_s       slave  input stream (data, control, exists in; read out)
//   fsl_m       master result stream (data, control, write out; full in)
//
//  Result word layout
//   [31]     found  a crossing was seen
//   [30]     trunc  packet cut short by an early header
//   [29:28]  zero
//   [27:12]  index of the first crossing (0 if none)
//   [11:0]   peak sample value
// ----------------------------------------------------------------------------
module us_echo_detector #(
    parameter int SAMPLE_W = 12,
    parameter int IDX_W    = 16
) (
    input  logic                FSL_Clk,
    input  logic                FSL_Rst_n,
    input  logic [SAMPLE_W-1:0] THRESHOLD,
    us_echo_detector_if.slave   fsl_s,
    us_echo_detector_if.master  fsl_m
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_EMIT_HDR,
        S_EMIT_RES
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    state_t              state_q;
    state_t              state_d;
    logic [31:0]         hdr_q;
    logic [SAMPLE_W-1:0] thr_q;
    logic [SAMPLE_W-1:0] peak_q;
    logic                found_q;
    logic                trunc_q;
    logic [IDX_W-1:0]    idx_q;
    logic [23:0]         cnt_q;     // samples accepted so far in this packet

    logic                s_read;
    logic                m_write;
    logic [31:0]         m_data;
    logic                m_control;

    logic [SAMPLE_W-1:0] sample;
    logic                last_sample;
    logic [IDX_W-1:0]    idx_sat;
    logic [31:0]         result_word;
    logic                hdr_accept;
    logic                sample_accept;

    // Only the low bits of an input word carry the ADC sample.
    assign sample = fsl_s.data[SAMPLE_W-1:0];

    // A RUN packet always has N >= 1, so N-1 never underflows here.
    assign last_sample = (cnt_q == hdr_q[31:8] - 24'd1);

    // The crossing index clamps at the largest value the field can hold.
    assign idx_sat = (cnt_q > 24'(IDX_MAX)) ? IDX_MAX : cnt_q[IDX_W-1:0];

    assign result_word = {found_q, trunc_q, 2'b00, 16'(idx_q), 12'(peak_q)};

    assign hdr_accept    = (state_q == S_IDLE) && fsl_s.exists && fsl_s.control;
    assign sample_accept = (state_q == S_RUN) && fsl_s.exists && !fsl_s.control;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        s_read    = 1'b0;
        m_write   = 1'b0;
        m_data    = '0;
        m_control = 1'b0;

        case (state_q)
            S_IDLE: begin
                // IDLE consumes every word. A stray data word is read and dropped.
                s_read = fsl_s.exists;
                if (hdr_accept) begin
                    state_d = (fsl_s.data[31:8] == 24'd0) ? S_EMIT_HDR : S_RUN;
                end
            end

            S_RUN: begin
                if (fsl_s.exists) begin
                    if (fsl_s.control) begin
                        // An early header ends this packet. It is left unread
                        // so IDLE can accept it as the start of the next packet.
                        state_d = S_EMIT_HDR;
                    end else begin
                        s_read = 1'b1;
                        if (last_sample) begin
                            state_d = S_EMIT_HDR;
                        end
                    end
                end
            end

            S_EMIT_HDR: begin
                m_write   = !fsl_m.full;
                m_data    = hdr_q;
                m_control = 1'b1;
                if (!fsl_m.full) begin
                    state_d = S_EMIT_RES;
                end
            end

            S_EMIT_RES: begin
                m_write = !fsl_m.full;
                m_data  = result_word;
                if (!fsl_m.full) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign fsl_s.read    = s_read;
    assign fsl_m.write   = m_write;
    assign fsl_m.data    = m_data;
    assign fsl_m.control = m_control;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
        if (!FSL_Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Packet datapath: latched header and threshold, running peak,
    // first-crossing tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
        if (!FSL_Rst_n) begin
            // NOTE: these are plain flops rather than a memory, so all of them are reset.
            hdr_q   <= '0;
            thr_q   <= '0;
            peak_q  <= '0;
            found_q <= 1'b0;
            trunc_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (hdr_accept) begin
                hdr_q   <= fsl_s.data;
                thr_q   <= THRESHOLD;
                peak_q  <= '0;
                found_q <= 1'b0;
                trunc_q <= 1'b0;
                idx_q   <= '0;
                cnt_q   <= '0;
            end

            if ((state_q == S_RUN) && fsl_s.exists && fsl_s.control) begin
                trunc_q <= 1'b1;
            end

            if (sample_accept) begin
                cnt_q <= cnt_q + 24'd1;
                if (sample > peak_q) begin
                    peak_q <= sample;
                end
                // Only the first crossing in a packet is recorded.
                if (!found_q && (sample >= thr_q)) begin
                    found_q <= 1'b1;
                    idx_q   <= idx_sat;
                end
            end
        end
    end

endmodule
